pll_lock_ctrl: RTL and testbench
================================

Name: pll_lock_ctrl

Overview:
- Sequences the on-chip PLL from the board crystal clock: drives PLL reset, loads dynamic divider selects (IDSEL/FBDSEL/ODSEL), waits for a stable lock and then releases the downstream reset.
- Supervises lock continuously: loss of lock re-runs the sequence; lock timeouts are retried up to a limit, then an error is flagged.
- Runs entirely on the reference clock, never on PLL output. Sits between the top level and the PLL wrapper.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per attempt (≥1).
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before declaring lock (≥1).
- LOCK_TIMEOUT, 240000: cycles allowed in WAIT_LOCK before a retry (10 ms at 24 MHz).
- MAX_RETRY, 3: consecutive timeouts before FAIL (≥1).
- INIT_IDSEL, 6'd0: select value after reset.
- INIT_FBDSEL, 6'd0: select value after reset.
- INIT_ODSEL, 6'd0: select value after reset.

Ports:
- sys_clk  in  1  reference clock (crystal)
- sys_rst_n  in  1  asynchronous active-low reset
- pll_lock  in  1  PLL LOCK, asynchronous to sys_clk
- cfg_valid  in  1  new divider configuration offered
- cfg_ready  out  1  controller accepts configuration
- cfg_idsel  in  6  requested IDSEL
- cfg_fbdsel  in  6  requested FBDSEL
- cfg_odsel  in  6  requested ODSEL
- pll_reset  out  1  PLL RESET, active high
- pll_idsel  out  6  registered IDSEL to PLL
- pll_fbdsel  out  6  registered FBDSEL to PLL
- pll_odsel  out  6  registered ODSEL to PLL
- locked  out  1  PLL locked and stable
- clk_rst_n  out  1  active-low reset for the PLL clock domain; each consumer domain must resynchronize its deassertion
- err  out  1  retries exhausted

Behaviour:
- Reset values (async on sys_rst_n low):
  - pll_reset=1, locked=0, clk_rst_n=0, err=0, cfg_ready=0.
  - pll_*sel = INIT_* values.
  - state=RESET_PLL, all counters and retry count = 0.
- pll_lock passes through a 2-flop synchronizer (lock_s). Every lock-dependent decision uses lock_s only.
- RESET_PLL:
  - pll_reset=1 for exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK; pll_reset falls on the same edge; timeout counter is cleared.
- WAIT_LOCK:
  - pll_reset=0; timeout counter increments every cycle.
  - lock_s=1 → STABLE with stable counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 without lock: retry+1. If the new retry == MAX_RETRY → FAIL; else → RESET_PLL.
- STABLE:
  - Stable counter increments while lock_s=1.
  - lock_s=0 → WAIT_LOCK. The timeout counter is not cleared (glitchy lock still times out).
  - Reaching LOCK_STABLE consecutive cycles → RUN.
- RUN:
  - locked=1, clk_rst_n=1, cfg_ready=1, retry=0.
  - On lock_s=0: next cycle locked=0, clk_rst_n=0, → RESET_PLL with retry=0.
- FAIL:
  - err=1, pll_reset=1 held, cfg_ready=1, locked=0, clk_rst_n=0.
  - Stays here until a configuration is accepted.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. cfg_ready is high only in RUN and FAIL.
  - On transfer: pll_*sel <= cfg_* and locked=0, clk_rst_n=0, err=0, retry=0, cfg_ready=0, all on the next edge; → RESET_PLL.
  - Select outputs change only on a transfer (or reset), so they are stable while pll_reset is asserted.
- Simultaneous events:
  - Transfer and lock loss in the same RUN cycle: the transfer wins (new selects load), then RESET_PLL.
  - Reset mid-operation: immediate return to reset values, including INIT selects.
- Latency from sys_rst_n release with pll_lock already high: pll_reset falls after RST_CYCLES cycles; locked rises 2 + LOCK_STABLE cycles later (±1 for the registered output, documented exactly in RTL comments).
- Counters are sized with $clog2 of their parameter and must not wrap: the terminal compare precedes any increment.

Decomposition:
- Package pll_ctrl_pkg holds:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL};
  - SEL_W=6.
- Sub-module sync_2ff: generic single-bit 2-flop synchronizer with async active-low reset to 0.

Test Plan (bench parameters RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=50, MAX_RETRY=2):
- Reset release, pll_lock tied 1 → pll_reset high 4 cycles; locked and clk_rst_n rise ~10 cycles later; cfg_ready=1; selects = INIT.
- pll_lock held 0 → two timeouts of 50 cycles, each preceded by a 4-cycle reset pulse; then err=1 and pll_reset stays 1.
- From FAIL, offer cfg {3,10,16} with pll_lock=1 → transfer in 1 cycle; err clears; pll_*sel={3,10,16}; locked returns.
- In RUN, drop pll_lock for 1 cycle → locked=0 and clk_rst_n=0 three cycles later; a 4-cycle pll_reset pulse; re-lock.
- In STABLE, pulse pll_lock low at count 5 → stable counter restarts; locked only after 8 unbroken cycles.
- In RUN, assert cfg_valid in the same cycle as a lock drop → new selects applied; exactly one RESET_PLL pass; sys_rst_n asserted mid-WAIT_LOCK → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller.
package pll_ctrl_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the async input into the i_clk domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up and lock supervisor running on the crystal reference clock.
// With pll_lock steady high from reset release: pll_reset falls on edge RST_CYCLES, locked rises on edge RST_CYCLES+1+LOCK_STABLE.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int               RST_CYCLES   = 16,
    parameter int               LOCK_STABLE  = 1024,
    parameter int               LOCK_TIMEOUT = 240000,
    parameter int               MAX_RETRY    = 3,
    parameter logic [SEL_W-1:0] INIT_IDSEL   = 6'd0,
    parameter logic [SEL_W-1:0] INIT_FBDSEL  = 6'd0,
    parameter logic [SEL_W-1:0] INIT_ODSEL   = 6'd0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pll_lock,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             locked,
    output logic             clk_rst_n,
    output logic             err
);

    localparam int RST_W = cnt_width(RST_CYCLES);
    localparam int STB_W = cnt_width(LOCK_STABLE);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT);
    localparam int RTY_W = cnt_width(MAX_RETRY + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    pll_state_e       r_state;
    logic [RST_W-1:0] r_rst_cnt;
    logic [STB_W-1:0] r_stb_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [RTY_W-1:0] r_retry;
    logic             r_pll_reset;
    logic             r_locked;
    logic             r_clk_rst_n;
    logic             r_err;
    logic             r_cfg_ready;
    logic [SEL_W-1:0] r_idsel;
    logic [SEL_W-1:0] r_fbdsel;
    logic [SEL_W-1:0] r_odsel;

    logic             w_lock_s;
    logic             w_xfer;
    logic [RTY_W-1:0] w_retry_next;

    sync_2ff u_lock_sync (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // cfg_ready is registered high only in RUN and FAIL, so it doubles as the state qualifier.
    assign w_xfer       = cfg_valid & r_cfg_ready;
    assign w_retry_next = r_retry + RTY_W'(1'b1);

    // Sequencer: every output is registered and updated on the state transition that defines it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= RESET_PLL;
            r_rst_cnt   <= {RST_W{1'b0}};
            r_stb_cnt   <= {STB_W{1'b0}};
            r_tmo_cnt   <= {TMO_W{1'b0}};
            r_retry     <= {RTY_W{1'b0}};
            r_pll_reset <= 1'b1;
            r_locked    <= 1'b0;
            r_clk_rst_n <= 1'b0;
            r_err       <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_idsel     <= INIT_IDSEL;
            r_fbdsel    <= INIT_FBDSEL;
            r_odsel     <= INIT_ODSEL;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state     <= WAIT_LOCK;
                        r_pll_reset <= 1'b0;
                        r_rst_cnt   <= {RST_W{1'b0}};
                        r_tmo_cnt   <= {TMO_W{1'b0}};
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1'b1);
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state   <= STABLE;
                        r_stb_cnt <= {STB_W{1'b0}};
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_retry     <= w_retry_next;
                        r_pll_reset <= 1'b1;
                        r_rst_cnt   <= {RST_W{1'b0}};
                        if (w_retry_next == RTY_MAX) begin
                            r_state     <= FAIL;
                            r_err       <= 1'b1;
                            r_cfg_ready <= 1'b1;
                        end else begin
                            r_state <= RESET_PLL;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1'b1);
                    end
                end
                STABLE: begin
                    // Timeout count is frozen here, so a chattering lock still runs out of time.
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_stb_cnt == STB_LAST) begin
                        r_state     <= RUN;
                        r_locked    <= 1'b1;
                        r_clk_rst_n <= 1'b1;
                        r_cfg_ready <= 1'b1;
                        r_retry     <= {RTY_W{1'b0}};
                    end else begin
                        r_stb_cnt <= r_stb_cnt + STB_W'(1'b1);
                    end
                end
                RUN, FAIL: begin
                    // A configuration transfer outranks a simultaneous lock loss.
                    if (w_xfer || (r_state == RUN && !w_lock_s)) begin
                        r_state     <= RESET_PLL;
                        r_rst_cnt   <= {RST_W{1'b0}};
                        r_retry     <= {RTY_W{1'b0}};
                        r_pll_reset <= 1'b1;
                        r_locked    <= 1'b0;
                        r_clk_rst_n <= 1'b0;
                        r_err       <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        if (w_xfer) begin
                            r_idsel  <= cfg_idsel;
                            r_fbdsel <= cfg_fbdsel;
                            r_odsel  <= cfg_odsel;
                        end
                    end
                end
                default: begin
                    r_state     <= RESET_PLL;
                    r_rst_cnt   <= {RST_W{1'b0}};
                    r_pll_reset <= 1'b1;
                    r_locked    <= 1'b0;
                    r_clk_rst_n <= 1'b0;
                    r_err       <= 1'b0;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset  = r_pll_reset;
    assign locked     = r_locked;
    assign clk_rst_n  = r_clk_rst_n;
    assign err        = r_err;
    assign cfg_ready  = r_cfg_ready;
    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: timestamp-based reference model, per-cycle compare, directed pins and random lock/config traffic.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 50;
    localparam int MAX_RETRY    = 2;
    localparam logic [5:0] INIT_ID = 6'd1;
    localparam logic [5:0] INIT_FB = 6'd2;
    localparam logic [5:0] INIT_OD = 6'd3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       pll_lock   = 1'b1;
    logic       cfg_valid  = 1'b0;
    logic [5:0] cfg_idsel  = 6'd0;
    logic [5:0] cfg_fbdsel = 6'd0;
    logic [5:0] cfg_odsel  = 6'd0;
    logic       cfg_ready;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       locked;
    logic       clk_rst_n;
    logic       err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state: phase plus timestamps/budgets rather than counters.
    int         m_phase = P_RST;
    int         m_cyc = 0;
    int         m_rst_exit = RST_CYCLES;
    int         m_wait_left = LOCK_TIMEOUT;
    int         m_stab_t0 = 0;
    int         m_timeouts = 0;
    bit         m_l1 = 1'b0;
    bit         m_l2 = 1'b0;
    logic [5:0] m_id = INIT_ID;
    logic [5:0] m_fb = INIT_FB;
    logic [5:0] m_od = INIT_OD;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY),
        .INIT_IDSEL   (INIT_ID),
        .INIT_FBDSEL  (INIT_FB),
        .INIT_ODSEL   (INIT_OD)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pll_lock   (pll_lock),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .locked     (locked),
        .clk_rst_n  (clk_rst_n),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk6(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Wait on negedges until the chosen output (0 pll_reset, 1 locked, 2 err) equals val.
    task automatic wait_for(input string name, input int which, input logic val, input int budget);
        logic cur;
        bit   hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge sys_clk);
            cur = (which == 0) ? pll_reset : ((which == 1) ? locked : err);
            if (cur === val) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: still not %0b after %0d cycles", name, val, budget);
        end
    endtask

    task automatic model_enter_rst();
        m_phase    = P_RST;
        m_rst_exit = m_cyc + RST_CYCLES;
    endtask

    // Reference model: advanced on each clock edge, cleared asynchronously by reset.
    initial begin
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                m_phase = P_RST; m_cyc = 0; m_rst_exit = RST_CYCLES;
                m_wait_left = LOCK_TIMEOUT; m_stab_t0 = 0; m_timeouts = 0;
                m_l1 = 1'b0; m_l2 = 1'b0;
                m_id = INIT_ID; m_fb = INIT_FB; m_od = INIT_OD;
            end else begin
                bit ls;
                bit xfer;
                ls    = m_l2;
                m_l2  = m_l1;
                m_l1  = pll_lock;
                m_cyc = m_cyc + 1;
                xfer  = cfg_valid && (m_phase == P_RUN || m_phase == P_FAIL);
                case (m_phase)
                    P_RST: if (m_cyc == m_rst_exit) begin
                        m_phase = P_WAIT;
                        m_wait_left = LOCK_TIMEOUT;
                    end
                    P_WAIT: if (ls) begin
                        m_phase = P_STAB;
                        m_stab_t0 = m_cyc;
                    end else begin
                        m_wait_left = m_wait_left - 1;
                        if (m_wait_left == 0) begin
                            m_timeouts = m_timeouts + 1;
                            if (m_timeouts == MAX_RETRY) m_phase = P_FAIL;
                            else model_enter_rst();
                        end
                    end
                    P_STAB: if (!ls) m_phase = P_WAIT;
                    else if (m_cyc - m_stab_t0 == LOCK_STABLE) begin
                        m_phase = P_RUN;
                        m_timeouts = 0;
                    end
                    P_RUN, P_FAIL: if (xfer || (m_phase == P_RUN && !ls)) begin
                        if (xfer) begin
                            m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
                        end
                        m_timeouts = 0;
                        model_enter_rst();
                    end
                    default: m_phase = P_RST;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_en) begin
                chk1("pll_reset", pll_reset, (m_phase == P_RST || m_phase == P_FAIL));
                chk1("locked",    locked,    (m_phase == P_RUN));
                chk1("clk_rst_n", clk_rst_n, (m_phase == P_RUN));
                chk1("cfg_ready", cfg_ready, (m_phase == P_RUN || m_phase == P_FAIL));
                chk1("err",       err,       (m_phase == P_FAIL));
                chk6("pll_idsel",  pll_idsel,  m_id);
                chk6("pll_fbdsel", pll_fbdsel, m_fb);
                chk6("pll_odsel",  pll_odsel,  m_od);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int hold_left;

        // Reset values, then bring-up with lock tied high.
        wait_n(3);
        chk1("pin_rst_pll_reset", pll_reset, 1'b1);
        chk1("pin_rst_locked", locked, 1'b0);
        chk1("pin_rst_cfg_ready", cfg_ready, 1'b0);
        chk6("pin_rst_idsel", pll_idsel, 6'd1);
        sys_rst_n = 1'b1;
        chk_en = 1'b1;
        wait_n(3);
        chk1("pin_bringup_rst_hi", pll_reset, 1'b1);
        wait_n(1);
        chk1("pin_bringup_rst_lo", pll_reset, 1'b0);
        wait_n(8);
        chk1("pin_bringup_not_locked", locked, 1'b0);
        wait_n(1);
        chk1("pin_bringup_locked", locked, 1'b1);
        chk1("pin_bringup_clk_rst_n", clk_rst_n, 1'b1);
        chk1("pin_bringup_cfg_ready", cfg_ready, 1'b1);
        chk6("pin_bringup_odsel", pll_odsel, 6'd3);

        // One-cycle lock drop in RUN.
        pll_lock = 1'b0;
        wait_n(1);
        pll_lock = 1'b1;
        wait_n(1);
        chk1("pin_drop_still_locked", locked, 1'b1);
        wait_n(1);
        chk1("pin_drop_unlocked", locked, 1'b0);
        chk1("pin_drop_clk_rst_n", clk_rst_n, 1'b0);
        wait_for("relock_after_drop", 1, 1'b1, 100);

        // Lock lost for good: two timeouts then FAIL.
        pll_lock = 1'b0;
        wait_n(110);
        chk1("pin_fail_not_yet", err, 1'b0);
        wait_n(1);
        chk1("pin_fail_err", err, 1'b1);
        wait_n(20);
        chk1("pin_fail_err_held", err, 1'b1);
        chk1("pin_fail_pll_reset_held", pll_reset, 1'b1);

        // Recover from FAIL with a new configuration.
        pll_lock = 1'b1;
        cfg_valid = 1'b1; cfg_idsel = 6'd3; cfg_fbdsel = 6'd10; cfg_odsel = 6'd16;
        wait_n(1);
        cfg_valid = 1'b0;
        chk1("pin_xfer_err_clear", err, 1'b0);
        chk1("pin_xfer_cfg_ready", cfg_ready, 1'b0);
        chk6("pin_xfer_idsel", pll_idsel, 6'd3);
        chk6("pin_xfer_fbdsel", pll_fbdsel, 6'd10);
        chk6("pin_xfer_odsel", pll_odsel, 6'd16);
        wait_for("relock_after_xfer", 1, 1'b1, 100);

        // Lock glitch while counting stability.
        pll_lock = 1'b0;
        wait_for("glitch_reset_hi", 0, 1'b1, 20);
        wait_for("glitch_reset_lo", 0, 1'b0, 20);
        pll_lock = 1'b1;
        wait_n(6);
        pll_lock = 1'b0;
        wait_n(1);
        pll_lock = 1'b1;
        wait_n(10);
        chk1("pin_glitch_not_locked", locked, 1'b0);
        wait_n(1);
        chk1("pin_glitch_locked", locked, 1'b1);

        // Transfer coinciding with a lock drop: one reset pass only.
        pll_lock = 1'b0;
        wait_n(2);
        cfg_valid = 1'b1; cfg_idsel = 6'd7; cfg_fbdsel = 6'd20; cfg_odsel = 6'd33;
        wait_n(1);
        cfg_valid = 1'b0;
        pll_lock = 1'b1;
        chk6("pin_both_idsel", pll_idsel, 6'd7);
        chk6("pin_both_odsel", pll_odsel, 6'd33);
        hi_cnt = pll_reset ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            wait_n(1);
            if (pll_reset) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 4) begin
            failures++;
            $display("FAIL pin_both_reset_cycles: got %0d expected 4", hi_cnt);
        end
        chk1("pin_both_locked", locked, 1'b1);

        // Asynchronous reset in the middle of WAIT_LOCK.
        pll_lock = 1'b0;
        wait_for("midwait_reset_hi", 0, 1'b1, 20);
        wait_for("midwait_reset_lo", 0, 1'b0, 20);
        wait_n(10);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk1("pin_async_pll_reset", pll_reset, 1'b1);
        chk1("pin_async_locked", locked, 1'b0);
        chk1("pin_async_clk_rst_n", clk_rst_n, 1'b0);
        chk1("pin_async_err", err, 1'b0);
        chk1("pin_async_cfg_ready", cfg_ready, 1'b0);
        chk6("pin_async_idsel", pll_idsel, 6'd1);
        chk6("pin_async_fbdsel", pll_fbdsel, 6'd2);
        chk6("pin_async_odsel", pll_odsel, 6'd3);
        wait_n(2);
        sys_rst_n = 1'b1;

        // Random lock behaviour and configuration offers.
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            wait_n(1);
            if (i == 2500) begin
                #3;
                sys_rst_n = 1'b0;
                wait_n(1);
                sys_rst_n = 1'b1;
            end
            if (hold_left == 0) begin
                pll_lock  = ($urandom_range(0, 3) != 0);
                hold_left = $urandom_range(1, 70);
            end
            hold_left  = hold_left - 1;
            cfg_valid  = ($urandom_range(0, 15) == 0);
            cfg_idsel  = 6'($urandom_range(0, 63));
            cfg_fbdsel = 6'($urandom_range(0, 63));
            cfg_odsel  = 6'($urandom_range(0, 63));
        end
        cfg_valid = 1'b0;
        wait_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
